// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit using restoring radix-2 division.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      done_rd
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_n;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rem_q, neg_q_q, neg_r_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       done_rd_q;

  logic             accept, signed_op, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             div_zero, ovf, early, special;
  logic [XLEN-1:0]  special_res;
  logic [XLEN+1:0]  sh, diff;
  logic [XLEN-1:0]  rem_step, quo_step, fin_res;
  logic             last_iter;

  assign accept    = start && !flush && (state_q == IDLE);
  assign signed_op = !op[0];
  assign a_neg     = signed_op && rs1_val[XLEN-1];
  assign b_neg     = signed_op && rs2_val[XLEN-1];
  assign a_mag     = a_neg ? -rs1_val : rs1_val;
  assign b_mag     = b_neg ? -rs2_val : rs2_val;
  assign div_zero  = (rs2_val == '0);
  assign ovf       = signed_op && (rs1_val == MIN_NEG) && (rs2_val == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  assign special = div_zero || ovf || early;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? rs1_val : '1;
    end else if (ovf) begin
      special_res = op[1] ? '0 : MIN_NEG;
    end else begin
      special_res = op[1] ? rs1_val : '0;
    end
  end

  // {rem,quo} shift plus trial subtract; two extra bits hold the carry-out and sign
  assign sh        = {1'b0, rem_q, quo_q[XLEN-1]};
  assign diff      = sh - {2'b00, dvs_q};
  assign rem_step  = XLEN'(diff[XLEN+1] ? sh : diff);
  assign quo_step  = {quo_q[XLEN-2:0], !diff[XLEN+1]};
  assign last_iter = (state_q == CALC) && (cnt_q == '0);

  always_comb begin
    fin_res = '0;
    if (is_rem_q) begin
      fin_res = neg_r_q ? -rem_step : rem_step;
    end else begin
      fin_res = neg_q_q ? -quo_step : quo_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_n = special ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      done_rd_q <= '0;
    end else if (accept) begin
      quo_q    <= a_mag;
      rem_q    <= '0;
      dvs_q    <= b_mag;
      cnt_q    <= CNT_W'(XLEN - 1);
      is_rem_q <= op[1];
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      rd_q     <= rd_addr;
      if (special) begin
        result_q  <= special_res;
        done_rd_q <= rd_addr;
      end
    end else if ((state_q == CALC) && !flush) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_iter) begin
        result_q  <= fin_res;
        done_rd_q <= rd_q;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign done_rd = done_rd_q;

endmodule
